// File: rtl/operand_fetch.sv
// ---------------------------------------------------------------------------
// operand_fetch
//
// Fetch stage in front of the 16-bit ALU. It accepts a decoded operation from
// the decoder and reads its register operands one byte at a time over the
// 8-bit external register-memory bus, because the register file is off-chip.
// It then presents the assembled operands and the ALU function with a
// valid/ready handshake.
//
// Parameters
//   ADDR_W       register address width; the memory byte address is
//                ADDR_W+1 bits wide ({reg_addr, byte_sel}, byte_sel 0 = low).
//
// Ports
//   clk          single clock, rising edge
//   rst          synchronous, active-high reset
//   req_valid    decoder offers an operation
//   req_ready    stage can accept (high only in IDLE)
//   req_func     ALU function: 00 ADD, 01 NAND, 10 PASS1, 11 EQ
//   req_addr1    register address of operand1
//   req_addr2    register address of operand2
//   req_imm_sel  operand2 comes from req_imm instead of memory
//   req_imm      16-bit immediate
//   mem_rd       read request, held until mem_ack
//   mem_addr     byte address of the current read
//   mem_rdata    read data, valid while mem_ack is high
//   mem_ack      completes the current read in the same cycle
//   out_valid    operands are ready for the ALU
//   out_ready    ALU/writeback consumes the operands
//   alu_func     latched ALU function
//   operand1     assembled operand1
//   operand2     assembled operand2
//
// Build option
//   OPFETCH_FWD_EN  when defined, a register-register operation whose two
//                   addresses are equal skips the second fetch and reuses
//                   the freshly assembled operand1 as operand2.
// ---------------------------------------------------------------------------
module operand_fetch #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    // decoder side
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_func,
    input  logic [ADDR_W-1:0] req_addr1,
    input  logic [ADDR_W-1:0] req_addr2,
    input  logic              req_imm_sel,
    input  logic [15:0]       req_imm,
    // external register-memory bus
    output logic              mem_rd,
    output logic [ADDR_W:0]   mem_addr,
    input  logic [7:0]        mem_rdata,
    input  logic              mem_ack,
    // ALU side
    output logic              out_valid,
    input  logic              out_ready,
    output logic [1:0]        alu_func,
    output logic [15:0]       operand1,
    output logic [15:0]       operand2
);

    localparam logic [1:0] FUNC_PASS1 = 2'b10;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RD1_LO = 3'd1,
        RD1_HI = 3'd2,
        RD2_LO = 3'd3,
        RD2_HI = 3'd4,
        OUT    = 3'd5
    } state_t;

    state_t              state_reg,   state_next;
    logic [1:0]          func_reg,    func_next;
    logic [ADDR_W-1:0]   addr1_reg,   addr1_next;
    logic [ADDR_W-1:0]   addr2_reg,   addr2_next;
    logic                imm_sel_reg, imm_sel_next;
    logic [15:0]         imm_reg,     imm_next;
    logic [15:0]         op1_reg,     op1_next;
    logic [15:0]         op2_reg,     op2_next;

    // Second fetch may be skipped when operand2 is already known after the
    // high byte of operand1 arrives.
    logic                skip_rd2;
    logic                fwd_hit;

    // -----------------------------------------------------------------------
    // State and datapath registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            func_reg    <= 2'b00;
            addr1_reg   <= '0;
            addr2_reg   <= '0;
            imm_sel_reg <= 1'b0;
            imm_reg     <= 16'h0000;
            op1_reg     <= 16'h0000;
            op2_reg     <= 16'h0000;
        end else begin
            state_reg   <= state_next;
            func_reg    <= func_next;
            addr1_reg   <= addr1_next;
            addr2_reg   <= addr2_next;
            imm_sel_reg <= imm_sel_next;
            imm_reg     <= imm_next;
            op1_reg     <= op1_next;
            op2_reg     <= op2_next;
        end
    end

    // -----------------------------------------------------------------------
    // Forwarding decision (only meaningful with the build option)
    // -----------------------------------------------------------------------
`ifdef OPFETCH_FWD_EN
    assign fwd_hit = (addr2_reg == addr1_reg);
`else
    assign fwd_hit = 1'b0;
`endif

    // The immediate wins over the PASS1 skip and over forwarding.
    assign skip_rd2 = imm_sel_reg || (func_reg == FUNC_PASS1) || fwd_hit;

    // -----------------------------------------------------------------------
    // Next-state and datapath update
    // -----------------------------------------------------------------------
    always_comb begin
        state_next   = state_reg;
        func_next    = func_reg;
        addr1_next   = addr1_reg;
        addr2_next   = addr2_reg;
        imm_sel_next = imm_sel_reg;
        imm_next     = imm_reg;
        op1_next     = op1_reg;
        op2_next     = op2_reg;

        case (state_reg)
            IDLE: begin
                if (req_valid) begin
                    func_next    = req_func;
                    addr1_next   = req_addr1;
                    addr2_next   = req_addr2;
                    imm_sel_next = req_imm_sel;
                    imm_next     = req_imm;
                    state_next   = RD1_LO;
                end
            end

            RD1_LO: begin
                if (mem_ack) begin
                    op1_next[7:0] = mem_rdata;
                    state_next    = RD1_HI;
                end
            end

            RD1_HI: begin
                if (mem_ack) begin
                    op1_next[15:8] = mem_rdata;
                    if (imm_sel_reg) begin
                        op2_next   = imm_reg;
                        state_next = OUT;
                    end else if (func_reg == FUNC_PASS1) begin
                        op2_next   = 16'h0000;
                        state_next = OUT;
                    end else if (skip_rd2) begin
                        // Forwarded: operand2 is operand1 as completed on
                        // this very edge, so build it from the live byte.
                        op2_next   = {mem_rdata, op1_reg[7:0]};
                        state_next = OUT;
                    end else begin
                        state_next = RD2_LO;
                    end
                end
            end

            RD2_LO: begin
                if (mem_ack) begin
                    op2_next[7:0] = mem_rdata;
                    state_next    = RD2_HI;
                end
            end

            RD2_HI: begin
                if (mem_ack) begin
                    op2_next[15:8] = mem_rdata;
                    state_next     = OUT;
                end
            end

            OUT: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Moore output decode
    // -----------------------------------------------------------------------
    always_comb begin
        req_ready = 1'b0;
        mem_rd    = 1'b0;
        mem_addr  = '0;
        out_valid = 1'b0;

        case (state_reg)
            IDLE:   req_ready = 1'b1;
            RD1_LO: begin
                mem_rd   = 1'b1;
                mem_addr = {addr1_reg, 1'b0};
            end
            RD1_HI: begin
                mem_rd   = 1'b1;
                mem_addr = {addr1_reg, 1'b1};
            end
            RD2_LO: begin
                mem_rd   = 1'b1;
                mem_addr = {addr2_reg, 1'b0};
            end
            RD2_HI: begin
                mem_rd   = 1'b1;
                mem_addr = {addr2_reg, 1'b1};
            end
            OUT:    out_valid = 1'b1;
            default: begin
                req_ready = 1'b0;
            end
        endcase
    end

    assign alu_func = func_reg;
    assign operand1 = op1_reg;
    assign operand2 = op2_reg;

endmodule

// File: tb/tb_operand_fetch.sv
// ---------------------------------------------------------------------------
// tb_operand_fetch
//
// Self-checking bench for operand_fetch. A byte-array memory model answers
// the read bus, and each operation's expected operands, read-address list and
// latency are derived from the architectural rules. Stimulus is a few
// directed operations followed by randomized ones with random bus stalls,
// random output back-pressure, stray acks and ignored request pulses.
// ---------------------------------------------------------------------------
module tb_operand_fetch;

    localparam int ADDR_W = 8;

`ifdef OPFETCH_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              req_valid;
    logic              req_ready;
    logic [1:0]        req_func;
    logic [ADDR_W-1:0] req_addr1;
    logic [ADDR_W-1:0] req_addr2;
    logic              req_imm_sel;
    logic [15:0]       req_imm;
    logic              mem_rd;
    logic [ADDR_W:0]   mem_addr;
    logic [7:0]        mem_rdata;
    logic              mem_ack;
    logic              out_valid;
    logic              out_ready;
    logic [1:0]        alu_func;
    logic [15:0]       operand1;
    logic [15:0]       operand2;

    logic [7:0] mem [0:(1<<(ADDR_W+1))-1];

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    operand_fetch #(.ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_func   (req_func),
        .req_addr1  (req_addr1),
        .req_addr2  (req_addr2),
        .req_imm_sel(req_imm_sel),
        .req_imm    (req_imm),
        .mem_rd     (mem_rd),
        .mem_addr   (mem_addr),
        .mem_rdata  (mem_rdata),
        .mem_ack    (mem_ack),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .alu_func   (alu_func),
        .operand1   (operand1),
        .operand2   (operand2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] word_at(input logic [7:0] a);
        return {mem[{a, 1'b1}], mem[{a, 1'b0}]};
    endfunction

    // One complete operation. Called at a falling edge with the stage idle.
    // st0..st3: cycles of mem_ack low before each read is acknowledged.
    // ord: cycles of out_ready low before the output handshake.
    task automatic run_op(input logic [1:0] func, input logic [7:0] a1, input logic [7:0] a2,
                          input logic isel, input logic [15:0] imm,
                          input int st0, input int st1, input int st2, input int st3,
                          input int ord);
        logic [8:0]  exp_addr[$];
        int          stalls[4];
        logic [15:0] e1, e2;
        int          idx, stall_cnt, total_stall, k;

        stalls = '{st0, st1, st2, st3};
        e1 = word_at(a1);
        exp_addr = {};
        exp_addr.push_back({a1, 1'b0});
        exp_addr.push_back({a1, 1'b1});
        if (isel)
            e2 = imm;
        else if (func == 2'b10)
            e2 = 16'h0000;
        else if (FWD && (a1 == a2))
            e2 = e1;
        else begin
            e2 = word_at(a2);
            exp_addr.push_back({a2, 1'b0});
            exp_addr.push_back({a2, 1'b1});
        end

        check("req_ready_idle", req_ready, 1);
        req_valid   = 1'b1;
        req_func    = func;
        req_addr1   = a1;
        req_addr2   = a2;
        req_imm_sel = isel;
        req_imm     = imm;
        mem_ack     = 1'b0;
        @(negedge clk);

        k = 1; idx = 0; stall_cnt = 0; total_stall = 0;
        while (!out_valid && k < 60) begin
            check("req_ready_busy", req_ready, 0);
            // stray requests while busy must be ignored
            req_valid   = 1'($urandom_range(0, 1));
            req_func    = 2'($urandom);
            req_addr1   = 8'($urandom);
            req_addr2   = 8'($urandom);
            req_imm_sel = 1'($urandom);
            req_imm     = 16'($urandom);
            if (mem_rd) begin
                if (idx < exp_addr.size())
                    check("mem_addr", mem_addr, exp_addr[idx]);
                else
                    check("extra_read", idx, exp_addr.size());
                mem_rdata = mem[mem_addr];
                if (idx < 4 && stall_cnt < stalls[idx]) begin
                    mem_ack = 1'b0;
                    stall_cnt++;
                    total_stall++;
                end else begin
                    mem_ack = 1'b1;
                    idx++;
                    stall_cnt = 0;
                end
            end else begin
                check("mem_rd_in_fetch", mem_rd, 1);
                mem_ack = 1'b0;
            end
            @(negedge clk);
            k++;
        end

        req_valid = 1'b0;
        mem_ack   = 1'($urandom_range(0, 1));
        mem_rdata = 8'($urandom);
        check("latency", k, 1 + exp_addr.size() + total_stall);
        check("read_count", idx, exp_addr.size());
        check("operand1", operand1, e1);
        check("operand2", operand2, e2);
        check("alu_func", alu_func, func);
        check("mem_rd_out", mem_rd, 0);

        for (int i = 0; i < ord; i++) begin
            out_ready = 1'b0;
            mem_ack   = 1'($urandom_range(0, 1));
            @(negedge clk);
            check("out_valid_hold", out_valid, 1);
            check("req_ready_hold", req_ready, 0);
            check("operand1_hold", operand1, e1);
            check("operand2_hold", operand2, e2);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        mem_ack   = 1'b0;
        check("req_ready_after", req_ready, 1);
        check("out_valid_after", out_valid, 0);
        check("operand1_idle", operand1, e1);
        check("operand2_idle", operand2, e2);
        check("alu_func_idle", alu_func, func);
        $display("op func=%0d a1=%02h a2=%02h imm_sel=%0d -> op1=%04h op2=%04h lat=%0d stalls=%0d",
                 func, a1, a2, isel, operand1, operand2, k, total_stall);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_req_ready"}, req_ready, 1);
        check({tag, "_mem_rd"}, mem_rd, 0);
        check({tag, "_mem_addr"}, mem_addr, 0);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_operand1"}, operand1, 0);
        check({tag, "_operand2"}, operand2, 0);
        check({tag, "_alu_func"}, alu_func, 0);
    endtask

    initial begin
        logic [7:0] ra1, ra2;

        rst = 1'b1; req_valid = 1'b0; req_func = 2'b00; req_addr1 = '0; req_addr2 = '0;
        req_imm_sel = 1'b0; req_imm = 16'h0; mem_rdata = 8'h0; mem_ack = 1'b0; out_ready = 1'b0;

        for (int i = 0; i < (1 << (ADDR_W + 1)); i++) mem[i] = 8'($urandom);
        mem[9'h00A] = 8'h34; mem[9'h00B] = 8'h12;
        mem[9'h012] = 8'hCD; mem[9'h013] = 8'hAB;
        mem[9'h002] = 8'hF0; mem[9'h003] = 8'hF0;
        mem[9'h004] = 8'h01; mem[9'h005] = 8'h80;
        mem[9'h00E] = 8'h5A; mem[9'h00F] = 8'h5A;
        mem[9'h020] = 8'h11; mem[9'h021] = 8'h22;

        repeat (3) @(negedge clk);
        check_reset_state("rst_held");
        rst = 1'b0;
        @(negedge clk);
        check_reset_state("rst_release");

        // directed operations
        run_op(2'b00, 8'h05, 8'h09, 1'b0, 16'h0000, 0, 0, 0, 0, 0);
        run_op(2'b01, 8'h01, 8'h44, 1'b1, 16'h00FF, 0, 0, 0, 0, 0);
        run_op(2'b10, 8'h02, 8'h33, 1'b0, 16'h0000, 0, 0, 0, 0, 0);
        run_op(2'b11, 8'h07, 8'h07, 1'b0, 16'h0000, 0, 0, 0, 0, 0);
        run_op(2'b00, 8'h05, 8'h09, 1'b0, 16'h0000, 0, 3, 0, 0, 2);

        // reset while in RD2_LO, with an ack pending
        req_valid = 1'b1; req_func = 2'b00; req_addr1 = 8'h10; req_addr2 = 8'h20;
        req_imm_sel = 1'b0; req_imm = 16'h0;
        @(negedge clk);
        req_valid = 1'b0;
        for (int i = 0; i < 10 && !(mem_rd && mem_addr == 9'h040); i++) begin
            mem_ack   = 1'b1;
            mem_rdata = mem[mem_addr];
            @(negedge clk);
        end
        check("reached_rd2_lo", mem_addr, 9'h040);
        rst = 1'b1;
        mem_ack = 1'b1;
        mem_rdata = mem[mem_addr];
        @(negedge clk);
        rst = 1'b0;
        mem_ack = 1'b0;
        check_reset_state("rst_mid");
        $display("reset mid-fetch applied");
        run_op(2'b00, 8'h10, 8'h20, 1'b0, 16'h0000, 0, 0, 0, 0, 0);

        // randomized operations
        for (int n = 0; n < 40; n++) begin
            ra1 = 8'($urandom);
            ra2 = ($urandom_range(0, 3) == 0) ? ra1 : 8'($urandom);
            run_op(2'($urandom), ra1, ra2, ($urandom_range(0, 3) == 0), 16'($urandom),
                   $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2),
                   $urandom_range(0, 2), $urandom_range(0, 2));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/operand_fetch.md
# operand_fetch

Fetch stage in front of the 16-bit ALU. It accepts a decoded operation (ALU function, two register addresses, optional immediate) from the decoder. It reads the register operands byte-serially over the 8-bit external register-memory bus and presents the assembled `operand1`/`operand2`/`alu_func` to the ALU with a valid/ready handshake. It exists because the register file lives off-chip behind the narrow pin bus.

## Interface
Parameters:
- `ADDR_W`, default 8: register address width; memory byte address is `ADDR_W+1` bits.

Ports:
- `clk` input 1: single clock; all logic on rising edge.
- `rst` input 1: synchronous, active-high reset.
- `req_valid` input 1: decoder offers an operation.
- `req_ready` output 1: stage can accept; high only in IDLE.
- `req_func` input 2: ALU function (00 ADD, 01 NAND, 10 PASS1, 11 EQ).
- `req_addr1` input ADDR_W: register address of operand1.
- `req_addr2` input ADDR_W: register address of operand2.
- `req_imm_sel` input 1: operand2 taken from `req_imm` instead of memory.
- `req_imm` input 16: immediate value.
- `mem_rd` output 1: read request; held until acknowledged.
- `mem_addr` output ADDR_W+1: byte address `{reg_addr, byte_sel}`; `byte_sel` 0 = low byte.
- `mem_rdata` input 8: read data, valid when `mem_ack` is high.
- `mem_ack` input 1: completes the current read in the same cycle.
- `out_valid` output 1: operands ready for the ALU.
- `out_ready` input 1: ALU/writeback consumes.
- `alu_func` output 2: latched `req_func`.
- `operand1` output 16: assembled operand1.
- `operand2` output 16: assembled operand2.

## Operation
- States: IDLE, RD1_LO, RD1_HI, RD2_LO, RD2_HI, OUT. `req_ready`, `mem_rd`, `mem_addr` and `out_valid` are Moore decodes of state plus latched addresses.
- IDLE: `req_ready`=1. On `req_valid`, latch func, addresses, `imm_sel` and imm, then go to RD1_LO.
- RDx_LO/RDx_HI: `mem_rd`=1 with `mem_addr` = `{addrX,0}` or `{addrX,1}`. While `mem_ack`=0, stay and hold the address. On `mem_ack`=1, capture `mem_rdata` into the low or high byte (little-endian) and advance.
- After RD1_HI:
  - If `imm_sel`: operand2 = imm, go to OUT.
  - Else if func = PASS1: operand2 = 0, go to OUT.
  - Else go to RD2_LO.
- RD2_HI with ack goes to OUT.
- OUT: `out_valid`=1. Operands and `alu_func` are stable. On `out_ready`, go to IDLE.
- `operand1`/`operand2`/`alu_func` registers change only on capture or at a new request latch. They hold their last values in IDLE.
- `mem_ack` outside RD states is ignored. `req_valid` outside IDLE is ignored, and the decoder holds its request.
- `imm_sel` takes priority over the PASS1 skip and over forwarding.

## Timing
- Reset values: state IDLE, `req_ready`=1, `mem_rd`=0, `mem_addr`=0, `out_valid`=0, `operand1`=`operand2`=0, `alu_func`=00.
- Reset mid-fetch: next cycle is IDLE with `mem_rd`=0. Partial data is discarded and a pending ack is ignored.
- Request accepted at edge T, with `mem_ack` tied high:
  - Two-register fetch: `mem_rd` high in cycles T+1..T+4; `out_valid` high from T+5.
  - Immediate or PASS1: `out_valid` high from T+3.
- Each cycle of `mem_ack` low adds one cycle of latency.
- OUT followed by `out_ready` at edge U: `req_ready`=1 at U+1. No request is accepted in the same cycle as the output handshake, so minimum issue interval is 6 cycles for a two-register fetch.

## Configuration
- Macro: `OPFETCH_FWD_EN`.
- Defined: when `imm_sel`=0, func ≠ PASS1 and `addr2 == addr1`, RD2 states are skipped and operand2 = the assembled operand1. Latency matches the immediate case (T+3).
- Undefined: operand2 is always fetched from memory as described above, even for equal addresses.

## Test plan
- Reset, then ADD with addr1=0x05, addr2=0x09, memory[0x0A,0x0B]=0x34,0x12 and [0x12,0x13]=0xCD,0xAB, ack always high -> `mem_addr` sequence 0x0A,0x0B,0x12,0x13; `out_valid` at T+5; operand1=0x1234, operand2=0xABCD, `alu_func`=00.
- NAND with `req_imm_sel`=1, imm=0x00FF, addr1=0x01 holding 0xF0F0 -> only two reads; operand2=0x00FF; `out_valid` at T+3.
- PASS1 with addr1=0x02 holding 0x8001 -> two reads, operand2=0x0000, `alu_func`=10.
- EQ, addr1=addr2=0x07 holding 0x5A5A:
  - With `OPFETCH_FWD_EN`: two reads, both operands 0x5A5A at T+3.
  - Without: four reads, `out_valid` at T+5.
- `mem_ack` low 3 cycles on RD1_HI and `out_ready` low 2 cycles in OUT -> `mem_addr` held stable during the stall; operands stable; `req_ready` stays 0 until the cycle after the `out_ready` handshake; a `req_valid` pulse during the stall is not accepted.
- Assert `rst` while in RD2_LO -> next cycle `mem_rd`=0, `req_ready`=1, `out_valid`=0, operands 0; a subsequent request completes normally.
